// File: rtl/interleave_example_pkg.sv
// interleave_example_pkg: shared types, limits and helpers for the interleave example read path
package interleave_example_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_req_state_t;

    localparam int unsigned LP_4KB_BOUNDARY = 4096;

    function automatic logic [63:0] ceil_div_pow2(input logic [63:0] x, input int unsigned lg);
        return (x >> lg) + 64'(|(x & ((64'd1 << lg) - 64'd1)));
    endfunction

endpackage

// File: rtl/interleave_example_counter.sv
// interleave_example_counter: up/down counter with load, clock enable and a registered zero flag
module interleave_example_counter #(
    parameter int                 C_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clken_i,
    input  logic               load_i,
    input  logic               incr_i,
    input  logic               decr_i,
    input  logic [C_WIDTH-1:0] load_value_i,
    output logic [C_WIDTH-1:0] count_o,
    output logic               is_zero_o
);

    logic [C_WIDTH-1:0] count_q, count_d;
    logic               is_zero_q;
    logic               dec;

    // a decrement at zero is a caller protocol error and is dropped
    assign dec     = decr_i & |count_q;
    assign count_d = load_i          ? load_value_i :
                     (incr_i & ~dec) ? count_q + 1'b1 :
                     (dec & ~incr_i) ? count_q - 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= C_INIT;
            is_zero_q <= (C_INIT == '0);
        end else if (clken_i) begin
            count_q   <= count_d;
            is_zero_q <= (count_d == '0);
        end
    end

    assign count_o   = count_q;
    assign is_zero_o = is_zero_q;

endmodule

// File: rtl/interleave_example_rd_req_gen.sv
// interleave_example_rd_req_gen: splits a byte transfer into fixed-length AXI AR bursts,
// limits in-flight bursts and pulses done once every burst has returned its last beat.
module interleave_example_rd_req_gen
    import interleave_example_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BURST_LEN       = 16,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_done,
    output logic                         busy,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    input  logic                         m_axi_rvalid,
    input  logic                         m_axi_rready,
    input  logic                         m_axi_rlast
);

    localparam int unsigned BPB         = C_DATA_WIDTH / 8;
    localparam int unsigned BPB_LG      = $clog2(BPB);
    localparam int          XW          = C_XFER_SIZE_WIDTH + 1;
    localparam int          CW          = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int unsigned BURST_BYTES = (C_BURST_LEN * BPB > LP_4KB_BOUNDARY) ? LP_4KB_BOUNDARY : C_BURST_LEN * BPB;

    rd_req_state_t          state_q, state_d;
    logic                   prep_q, prep_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XW-1:0]          size_q, size_d;
    logic [XW-1:0]          bursts_q, bursts_d;
    logic [8:0]             last_q, last_d;
    logic [XW-1:0]          beats, nb;
    logic [8:0]             last_len;
    logic [CW-1:0]          outstanding;
    logic                   out_zero;
    logic                   ar_hs;

    assign beats    = XW'(ceil_div_pow2(64'(size_q), BPB_LG));
    assign nb       = (beats + XW'(C_BURST_LEN - 1)) / XW'(C_BURST_LEN);
    assign last_len = 9'(beats - (nb - XW'(1)) * XW'(C_BURST_LEN));

    // prep_q spends the first ISSUE cycle registering the burst count and tail length
    assign m_axi_arvalid = (state_q == ISSUE) && !prep_q && (bursts_q != '0) && (outstanding != CW'(C_MAX_OUTSTANDING));
    assign ar_hs         = m_axi_arvalid & m_axi_arready;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = !m_axi_arvalid ? 8'd0 : (bursts_q == XW'(1)) ? 8'(last_q - 9'd1) : 8'(C_BURST_LEN - 1);
    assign ctrl_done     = (state_q == DONE);
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        prep_d   = prep_q;
        addr_d   = addr_q;
        size_d   = size_q;
        bursts_d = bursts_q;
        last_d   = last_q;
        case (state_q)
            IDLE: if (ctrl_start) begin
                addr_d  = ctrl_addr_offset;
                size_d  = XW'(ctrl_xfer_size_in_bytes);
                prep_d  = 1'b1;
                state_d = (ctrl_xfer_size_in_bytes == '0) ? DONE : ISSUE;
            end
            ISSUE: if (prep_q) begin
                prep_d   = 1'b0;
                bursts_d = nb;
                last_d   = last_len;
            end else if (ar_hs) begin
                bursts_d = bursts_q - XW'(1);
                addr_d   = addr_q + C_ADDR_WIDTH'(BURST_BYTES);
                state_d  = (bursts_q == XW'(1)) ? DRAIN : ISSUE;
            end
            DRAIN: state_d = out_zero ? DONE : DRAIN;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prep_q   <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            bursts_q <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            prep_q   <= prep_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            bursts_q <= bursts_d;
            last_q   <= last_d;
        end
    end

    interleave_example_counter #(
        .C_WIDTH (CW),
        .C_INIT  ('0)
    ) u_outstanding (
        .clk          (clk),
        .rst          (rst),
        .clken_i      (1'b1),
        .load_i       (1'b0),
        .incr_i       (ar_hs),
        .decr_i       (m_axi_rvalid & m_axi_rready & m_axi_rlast),
        .load_value_i ('0),
        .count_o      (outstanding),
        .is_zero_o    (out_zero)
    );

endmodule

// File: tb/tb_interleave_example_rd_req_gen.sv
// tb_interleave_example_rd_req_gen: randomized AR/R traffic checked against a burst-list scoreboard
module tb_interleave_example_rd_req_gen;

    localparam int MAXO = 4;
    localparam int BL   = 16;
    localparam int BPB  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_start = 1'b0;
    logic [63:0] ctrl_addr_offset = '0;
    logic [31:0] ctrl_xfer_size_in_bytes = '0;
    logic        ctrl_done, busy;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready = 1'b0;
    logic        m_axi_rlast = 1'b0;

    interleave_example_rd_req_gen #(
        .C_ADDR_WIDTH      (64),
        .C_DATA_WIDTH      (512),
        .C_XFER_SIZE_WIDTH (32),
        .C_BURST_LEN       (BL),
        .C_MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ctrl_start              (ctrl_start),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_done               (ctrl_done),
        .busy                    (busy),
        .m_axi_arvalid           (m_axi_arvalid),
        .m_axi_arready           (m_axi_arready),
        .m_axi_araddr            (m_axi_araddr),
        .m_axi_arlen             (m_axi_arlen),
        .m_axi_rvalid            (m_axi_rvalid),
        .m_axi_rready            (m_axi_rready),
        .m_axi_rlast             (m_axi_rlast)
    );

    always #5 clk = ~clk;

    int pass_n = 0;
    int total_n = 0;
    int outst = 0;
    longint unsigned q_addr[$];
    int q_len[$];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total_n++;
        assert (o === e) pass_n++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // expected burst list straight from the size/offset arithmetic
    task automatic build(input longint unsigned off, input longint unsigned sz);
        longint unsigned beats = (sz + BPB - 1) / BPB;
        longint unsigned nb = (beats + BL - 1) / BL;
        q_addr.delete();
        q_len.delete();
        for (longint unsigned k = 0; k < nb; k++) begin
            q_addr.push_back(off + k * BL * BPB);
            q_len.push_back(int'((k == nb - 1) ? beats - (nb - 1) * BL - 1 : BL - 1));
        end
    endtask

    task automatic run_xfer(input longint unsigned off, input longint unsigned sz, input int rdy_mode, input int rl_pct, input int hold);
        bit exp_done = 1'b0;
        bit first = 1'b1;
        bit stalled = 1'b0;
        bit hs, dec;
        logic [63:0] paddr = '0;
        logic [7:0] plen = '0;
        int cyc = 0;
        int k;
        build(off, sz);
        ctrl_addr_offset = off;
        ctrl_xfer_size_in_bytes = 32'(sz);
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        chk("busy_t1", busy, 1);
        if (sz == 0) begin
            chk("done_zero_t1", ctrl_done, 1);
            chk("arvalid_zero", m_axi_arvalid, 0);
            tick();
            chk("busy_zero_t2", busy, 0);
            chk("done_zero_t2", ctrl_done, 0);
            return;
        end
        while (1) begin
            chk("done", ctrl_done, exp_done);
            if (exp_done) break;
            chk("busy", busy, 1);
            chk("arvalid", m_axi_arvalid, !first && q_addr.size() > 0 && outst < MAXO);
            if (stalled) begin
                chk("araddr_hold", m_axi_araddr, paddr);
                chk("arlen_hold", m_axi_arlen, plen);
            end
            exp_done = q_addr.size() == 0 && outst == 0;
            m_axi_arready = (rdy_mode >= 100) ? 1'b1 : (rdy_mode < 0) ? (cyc % 6 == 5) : ($urandom % 100 < rdy_mode);
            k = int'($urandom % 20);
            if (cyc >= hold && outst > 0 && ($urandom % 100) < rl_pct) {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b111;
            else if (k == 0) {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b101;
            else if (k == 1 && outst == 0) {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b111;
            else if (k == 2) {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b110;
            else {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b000;
            // starts while busy must be ignored
            ctrl_start = ($urandom % 8 == 0);
            ctrl_addr_offset = {$urandom, $urandom};
            ctrl_xfer_size_in_bytes = $urandom;
            hs = m_axi_arvalid && m_axi_arready;
            if (hs && q_addr.size() > 0) begin
                chk("araddr", m_axi_araddr, q_addr[0]);
                chk("arlen", 64'(m_axi_arlen), 64'(q_len[0]));
                void'(q_addr.pop_front());
                void'(q_len.pop_front());
            end
            stalled = m_axi_arvalid && !m_axi_arready;
            paddr = m_axi_araddr;
            plen = m_axi_arlen;
            dec = m_axi_rvalid && m_axi_rready && m_axi_rlast && outst > 0;
            outst = outst + int'(hs) - int'(dec);
            cyc++;
            if (cyc > 3000) begin
                chk("timeout", 0, 1);
                break;
            end
            tick();
            first = 1'b0;
        end
        ctrl_start = 1'b0;
        m_axi_arready = 1'b0;
        {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b000;
        tick();
        chk("busy_idle", busy, 0);
        chk("done_idle", ctrl_done, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_done", ctrl_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        rst = 1'b0;
        tick();
        run_xfer(64'h1000_0000, 4096, 100, 50, 0);
        run_xfer(64'h2000, 100, 100, 60, 0);
        run_xfer(64'h3000, 0, 100, 50, 0);
        run_xfer(64'h4000, 8 * 1024, -1, 50, 40);
        run_xfer(64'h8000, 8192, 100, 30, 20);
        run_xfer(64'hFFFF_FFFF_FFFF_F800, 4096, 100, 50, 0);
        repeat (6) run_xfer({$urandom, $urandom} & ~64'h3FF, $urandom_range(1, 20000), $urandom_range(20, 100), $urandom_range(10, 90), $urandom_range(0, 30));
        // reset in the middle of issuing: second handshake and reset share an edge
        ctrl_addr_offset = 64'h5_0000;
        ctrl_xfer_size_in_bytes = 4096;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        m_axi_arready = 1'b1;
        tick();
        chk("mid_arvalid1", m_axi_arvalid, 1);
        chk("mid_araddr1", m_axi_araddr, 64'h5_0000);
        tick();
        chk("mid_araddr2", m_axi_araddr, 64'h5_0400);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_axi_arready = 1'b0;
        outst = 0;
        chk("mid_rst_arvalid", m_axi_arvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", ctrl_done, 0);
        run_xfer(64'hC_0000, 1024, 100, 50, 0);
        run_xfer(64'hD_0000, 8192, 100, 40, 15);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/interleave_example_rd_req_gen.md
# interleave_example_rd_req_gen

Read-request generator feeding the interleave example's AXI4 read master channel. On a start pulse it splits a byte-sized transfer into fixed-length AR bursts, caps in-flight bursts with an outstanding-transaction counter, and watches R-channel last beats to detect completion. It sits between the kernel control registers and the `m_axi` read port; `interleave_example_counter` tracks outstanding bursts.

## Interface
- `C_ADDR_WIDTH`, 64, AXI address width
- `C_DATA_WIDTH`, 512, AXI data width; `C_DATA_WIDTH/8` is a power of two
- `C_XFER_SIZE_WIDTH`, 32, width of the byte-count input
- `C_BURST_LEN`, 16, beats per full burst, 1..256
- `C_MAX_OUTSTANDING`, 16, in-flight burst limit, at least 1

- `clk` in 1: sole clock
- `rst` in 1: synchronous, active-high reset
- `ctrl_start` in 1: one-cycle start pulse
- `ctrl_addr_offset` in C_ADDR_WIDTH: base byte address, sampled with start
- `ctrl_xfer_size_in_bytes` in C_XFER_SIZE_WIDTH: transfer length, sampled with start
- `ctrl_done` out 1: one-cycle completion pulse
- `busy` out 1: high from the cycle after an accepted start until the `ctrl_done` cycle, inclusive
- `m_axi_arvalid` out 1: AR valid
- `m_axi_arready` in 1: AR ready
- `m_axi_araddr` out C_ADDR_WIDTH: burst address
- `m_axi_arlen` out 8: beats-1
- `m_axi_rvalid` in 1: observed only
- `m_axi_rready` in 1: observed only
- `m_axi_rlast` in 1: observed only

## Operation
- BPB = C_DATA_WIDTH/8.
- beats = ceil(size/BPB).
- bursts = ceil(beats/C_BURST_LEN).
- Last burst length = beats − (bursts−1)·C_BURST_LEN.
- Arithmetic is done in C_XFER_SIZE_WIDTH+1 bits, so there is no overflow.
- Burst k address = offset + k·C_BURST_LEN·BPB, modulo 2^C_ADDR_WIDTH.
- Caller preconditions, not checked:
  - offset is aligned to C_BURST_LEN·BPB.
  - C_BURST_LEN·BPB ≤ 4096, so no burst crosses a 4 KB boundary.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: `ctrl_start` latches the inputs. If size is 0, go to DONE; otherwise go to ISSUE.
  - ISSUE: drive AR while bursts remain. After the final AR handshake, go to DRAIN.
  - DRAIN: wait until the outstanding count reaches zero, then go to DONE.
  - DONE: assert `ctrl_done` for 1 cycle, then go to IDLE.
- `ctrl_start` outside IDLE is ignored.
- AR handshake = `arvalid & arready`.
  - While `arvalid` is high and `arready` is low, `araddr` and `arlen` hold stable and `arvalid` stays high.
- Outstanding counter (`interleave_example_counter`, width clog2(C_MAX_OUTSTANDING+1)):
  - incr on AR handshake.
  - decr on `rvalid & rready & rlast`.
  - Both in the same cycle leave the count unchanged.
- `arvalid` is deasserted whenever the registered count equals C_MAX_OUTSTANDING, even if a decr occurs in that same cycle.
- An `rlast` handshake when the count is zero is a protocol error. It is ignored (no decrement).
- Reset returns to IDLE from any state, clears the counter, and discards the latched transfer.

## Timing
- Reset values:
  - `m_axi_arvalid`=0, `ctrl_done`=0, `busy`=0.
  - `m_axi_araddr`=0, `m_axi_arlen`=0.
- Start sampled at cycle t:
  - `busy`=1 at t+1.
  - First `arvalid` at t+2: one cycle to register the beat and burst counts.
- After an AR handshake at cycle n, the next AR (if permitted) is valid at n+1, giving back-to-back bursts at full rate.
- Final AR handshake at cycle a: state is DRAIN at a+1.
- Outstanding count reaches zero at cycle u: `ctrl_done`=1 at u+1; IDLE at u+2. A start is accepted at u+2.
- Zero-size start at t: `ctrl_done`=1 at t+1; no AR is issued.
- Counter `is_zero` is registered, so DRAIN exits one cycle after the last decrement.

## Structure
- Package `interleave_example_pkg` holds:
  - The state enum `rd_req_state_t`.
  - The 4 KB limit constant.
  - The function computing ceil-divide by a power of two.
- One sub-module: `interleave_example_counter`, used for the outstanding count with `load` tied to 0 and `clken` tied to 1.
- Beat and burst down-counters stay inline.

## Test plan
- 4096 B, BPB=64, burst 16, arready=1 → 4 ARs with arlen=15 at offset+0/+1024/+2048/+3072 on consecutive cycles; `ctrl_done` 1 cycle after the 4th rlast handshake.
- 100 B → exactly 1 AR with arlen=1; done after its single rlast.
- 0 B → no arvalid; `ctrl_done` at t+1, `busy` high only at t+1.
- C_MAX_OUTSTANDING=2, 8 bursts, rlast withheld:
  - arvalid drops after 2 handshakes.
  - Releasing one rlast lets exactly one more AR through.
  - araddr and arlen stay stable during arready=0 stalls of 5 cycles.
- AR handshake coincident with rlast at count=1 → count stays 1; at count=max with rlast, arvalid is low that cycle.
- rst asserted mid-ISSUE after 2 of 4 bursts → arvalid=0 and busy=0 next cycle; a new 1024 B start is accepted and issues 1 AR at the new offset.
